clint_timer: RTL and testbench



---
 rtl/clint_pkg.sv | 44 ++++
 rtl/clint_prescaler.sv | 25 ++
 rtl/clint_timer.sv | 132 +++++++++++++
 tb/tb_clint_timer.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/clint_pkg.sv
// Shared CLINT definitions: register offsets, decoded register select and bus helpers.
package clint_pkg;

    localparam logic [15:0] CLINT_MSIP_OFF        = 16'h0000;
    localparam logic [15:0] CLINT_MTIMECMP_LO_OFF = 16'h4000;
    localparam logic [15:0] CLINT_MTIMECMP_HI_OFF = 16'h4004;
    localparam logic [15:0] CLINT_MTIME_LO_OFF    = 16'hBFF8;
    localparam logic [15:0] CLINT_MTIME_HI_OFF    = 16'hBFFC;

    typedef enum logic [2:0] {
        REG_NONE,
        REG_MSIP,
        REG_MTIMECMP_LO,
        REG_MTIMECMP_HI,
        REG_MTIME_LO,
        REG_MTIME_HI
    } clint_reg_e;

    function automatic logic [31:0] apply_be(input logic [31:0] old,
                                             input logic [31:0] wdata,
                                             input logic [3:0]  be);
        logic [31:0] res;
        res = old;
        for (int i = 0; i < 4; i++) begin
            if (be[i]) res[8*i +: 8] = wdata[8*i +: 8];
        end
        return res;
    endfunction

    // Exact 16-bit match, so misaligned offsets fall through to REG_NONE.
    function automatic clint_reg_e decode_addr(input logic [15:0] addr);
        clint_reg_e r;
        case (addr)
            CLINT_MSIP_OFF:        r = REG_MSIP;
            CLINT_MTIMECMP_LO_OFF: r = REG_MTIMECMP_LO;
            CLINT_MTIMECMP_HI_OFF: r = REG_MTIMECMP_HI;
            CLINT_MTIME_LO_OFF:    r = REG_MTIME_LO;
            CLINT_MTIME_HI_OFF:    r = REG_MTIME_HI;
            default:               r = REG_NONE;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/clint_prescaler.sv
// mtime prescaler: counts 0..TICK_DIV-1 and pulses tick on the last count.
module clint_prescaler
    import clint_pkg::*;
#(
    parameter int unsigned TICK_DIV = 1
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick
);

    localparam int unsigned CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    assign tick  = (cnt_q == LAST);
    assign cnt_d = tick ? '0 : cnt_q + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

endmodule

// File: rtl/clint_timer.sv
// Single-hart CLINT: mtime/mtimecmp/msip behind a one-outstanding valid/ready port.
// Optional CLINT_HI_LATCH_EN: a read of mtime lo snapshots mtime hi for atomic 64-bit reads.
module clint_timer
    import clint_pkg::*;
#(
    parameter int unsigned TICK_DIV  = 1,
    parameter logic [63:0] MTIME_RST = 64'h0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [15:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_be,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        mtip,
    output logic        msip
);

    logic [63:0] mtime_q, mtime_d;
    logic [63:0] mtimecmp_q, mtimecmp_d;
    logic        msip_q, msip_d;
    logic        mtip_q;
    logic        resp_valid_q, resp_valid_d;
    logic        resp_err_q, resp_err_d;
    logic [31:0] resp_rdata_q, resp_rdata_d;
    logic [31:0] rd_val, mtime_hi_rd;
    logic        tick, accept, wr_en;
    clint_reg_e  reg_sel;

    clint_prescaler #(.TICK_DIV(TICK_DIV)) u_presc (
        .clk   (clk),
        .rst_n (rst_n),
        .tick  (tick)
    );

    assign req_ready = !resp_valid_q;
    assign accept    = req_valid && req_ready;
    assign reg_sel   = decode_addr(req_addr);
    assign wr_en     = accept && req_we && (reg_sel != REG_NONE);

`ifdef CLINT_HI_LATCH_EN
    logic [31:0] hi_shadow_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            hi_shadow_q <= '0;
        else if (accept && !req_we && reg_sel == REG_MTIME_LO)
            hi_shadow_q <= mtime_q[63:32];
    end

    assign mtime_hi_rd = hi_shadow_q;
`else
    assign mtime_hi_rd = mtime_q[63:32];
`endif

    always_comb begin
        rd_val = '0;
        case (reg_sel)
            REG_MSIP:        rd_val = {31'b0, msip_q};
            REG_MTIMECMP_LO: rd_val = mtimecmp_q[31:0];
            REG_MTIMECMP_HI: rd_val = mtimecmp_q[63:32];
            REG_MTIME_LO:    rd_val = mtime_q[31:0];
            REG_MTIME_HI:    rd_val = mtime_hi_rd;
            default:         rd_val = '0;
        endcase
    end

    // A software write to either mtime half suppresses that cycle's increment.
    always_comb begin
        mtimecmp_d = mtimecmp_q;
        msip_d     = msip_q;
        mtime_d    = tick ? mtime_q + 64'd1 : mtime_q;
        if (wr_en) begin
            case (reg_sel)
                REG_MSIP:        if (req_be[0]) msip_d = req_wdata[0];
                REG_MTIMECMP_LO: mtimecmp_d[31:0]  = apply_be(mtimecmp_q[31:0], req_wdata, req_be);
                REG_MTIMECMP_HI: mtimecmp_d[63:32] = apply_be(mtimecmp_q[63:32], req_wdata, req_be);
                REG_MTIME_LO:    mtime_d = {mtime_q[63:32], apply_be(mtime_q[31:0], req_wdata, req_be)};
                REG_MTIME_HI:    mtime_d = {apply_be(mtime_q[63:32], req_wdata, req_be), mtime_q[31:0]};
                default:         ;
            endcase
        end
    end

    always_comb begin
        resp_valid_d = resp_valid_q;
        resp_rdata_d = resp_rdata_q;
        resp_err_d   = resp_err_q;
        if (accept) begin
            resp_valid_d = 1'b1;
            resp_err_d   = (reg_sel == REG_NONE);
            resp_rdata_d = req_we ? 32'h0 : rd_val;
        end else if (resp_valid_q && resp_ready) begin
            resp_valid_d = 1'b0;
            resp_rdata_d = '0;
            resp_err_d   = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mtime_q      <= MTIME_RST;
            mtimecmp_q   <= '1;
            msip_q       <= 1'b0;
            mtip_q       <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= '0;
            resp_err_q   <= 1'b0;
        end else begin
            mtime_q      <= mtime_d;
            mtimecmp_q   <= mtimecmp_d;
            msip_q       <= msip_d;
            mtip_q       <= (mtime_q >= mtimecmp_q);
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
            resp_err_q   <= resp_err_d;
        end
    end

    assign resp_valid = resp_valid_q;
    assign resp_rdata = resp_rdata_q;
    assign resp_err   = resp_err_q;
    assign mtip       = mtip_q;
    assign msip       = msip_q;

endmodule

// File: tb/tb_clint_timer.sv
// Directed bench for clint_timer: one instance at TICK_DIV=1 and one at TICK_DIV=4 on a shared bus.
module tb_clint_timer;

    logic        clk, rst_n, sel_dut;
    logic        req_valid, req_we, resp_ready;
    logic [15:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_be;

    logic        rr1, rv1, re1, mtip1, msip1;
    logic        rr4, rv4, re4, mtip4, msip4;
    logic [31:0] rd1, rd4;

    logic        req_ready, resp_valid, resp_err, mtip, msip;
    logic [31:0] resp_rdata;

    int n_chk = 0;
    int n_err = 0;

    logic [31:0] rd;
    logic        er;

    clint_timer #(.TICK_DIV(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid & ~sel_dut), .req_ready(rr1), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
        .resp_valid(rv1), .resp_ready(resp_ready & ~sel_dut),
        .resp_rdata(rd1), .resp_err(re1), .mtip(mtip1), .msip(msip1)
    );

    clint_timer #(.TICK_DIV(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid & sel_dut), .req_ready(rr4), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
        .resp_valid(rv4), .resp_ready(resp_ready & sel_dut),
        .resp_rdata(rd4), .resp_err(re4), .mtip(mtip4), .msip(msip4)
    );

    assign req_ready  = sel_dut ? rr4   : rr1;
    assign resp_valid = sel_dut ? rv4   : rv1;
    assign resp_rdata = sel_dut ? rd4   : rd1;
    assign resp_err   = sel_dut ? re4   : re1;
    assign mtip       = sel_dut ? mtip4 : mtip1;
    assign msip       = sel_dut ? msip4 : msip1;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One full transaction; align holds the request until the TICK_DIV=4 instance is in its tick cycle.
    task automatic bus(input logic we, input logic [15:0] addr, input logic [31:0] wdata,
                       input logic [3:0] be, input logic align,
                       output logic [31:0] rdata, output logic err);
        int n;
        @(negedge clk);
        if (align) begin
            n = 0;
            while (!u_dut4.u_presc.tick && n < 16) begin
                @(negedge clk);
                n++;
            end
            check("align_tick", u_dut4.u_presc.tick, 1);
        end
        req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata; req_be = be;
        @(posedge clk);
        #1 req_valid = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!resp_valid && n < 16);
        check("resp_valid", resp_valid, 1);
        rdata = resp_rdata;
        err   = resp_err;
        resp_ready = 1'b1;
        @(posedge clk);
        #1 resp_ready = 1'b0;
    endtask

    task automatic wr(input logic [15:0] addr, input logic [31:0] wdata, input logic [3:0] be);
        logic [31:0] d;
        logic        e;
        bus(1'b1, addr, wdata, be, 1'b0, d, e);
    endtask

    initial begin
        rst_n = 1'b0; sel_dut = 1'b0;
        req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0; req_be = '0;
        resp_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_req_ready", req_ready, 1);
        check("rst_resp_valid", resp_valid, 0);
        check("rst_resp_rdata", resp_rdata, 0);
        check("rst_resp_err", resp_err, 0);
        check("rst_mtip", mtip, 0);
        check("rst_msip", msip, 0);
        rst_n = 1'b1;
        repeat (10) @(posedge clk);

        bus(1'b0, 16'hBFF8, 32'h0, 4'h0, 1'b0, rd, er);
        check("mtime_after_10", rd, 32'd10);
        check("idle_mtip", mtip, 0);
        check("idle_msip", msip, 0);
        bus(1'b0, 16'h4000, 32'h0, 4'h0, 1'b0, rd, er);
        check("mtimecmp_rst_lo", rd, 32'hFFFF_FFFF);
        bus(1'b0, 16'h4004, 32'h0, 4'h0, 1'b0, rd, er);
        check("mtimecmp_rst_hi", rd, 32'hFFFF_FFFF);

        wr(16'h4004, 32'h0, 4'hF);
        wr(16'h4000, 32'h20, 4'hF);
        wr(16'hBFF8, 32'h1C, 4'hF);
        repeat (4) @(negedge clk);
        check("mtip_at_reach", mtip, 0);
        @(negedge clk);
        check("mtip_one_after", mtip, 1);
        wr(16'h4000, 32'hFFFF_FFFF, 4'hF);
        check("mtip_clear", mtip, 0);

        wr(16'hBFFC, 32'h0, 4'hF);
        wr(16'hBFF8, 32'hFFFF_FFFF, 4'hF);
        bus(1'b0, 16'hBFF8, 32'h0, 4'h0, 1'b0, rd, er);
        check("carry_lo", rd, 32'h0);
        bus(1'b0, 16'hBFFC, 32'h0, 4'h0, 1'b0, rd, er);
        check("carry_hi", rd, 32'h1);

        wr(16'hBFFC, 32'hFFFF_FFFF, 4'hF);
        wr(16'hBFF8, 32'hFFFF_FFFF, 4'hF);
        bus(1'b0, 16'hBFF8, 32'h0, 4'h0, 1'b0, rd, er);
        check("wrap_lo", rd, 32'h0);
        bus(1'b0, 16'hBFFC, 32'h0, 4'h0, 1'b0, rd, er);
        check("wrap_hi", rd, 32'h0);

        wr(16'h4004, 32'hFFFF_FFFF, 4'hF);
        bus(1'b1, 16'h4000, 32'h00AB_0000, 4'b0100, 1'b0, rd, er);
        check("be_write_err", er, 0);
        check("be_write_rdata", rd, 0);
        bus(1'b0, 16'h4000, 32'h0, 4'h0, 1'b0, rd, er);
        check("be_lane2", rd, 32'hFFAB_FFFF);

        wr(16'h0000, 32'hFFFF_FFFF, 4'hF);
        check("msip_set", msip, 1);
        bus(1'b0, 16'h0000, 32'h0, 4'h0, 1'b0, rd, er);
        check("msip_read", rd, 32'h1);
        wr(16'h0000, 32'h0, 4'b0010);
        check("msip_lane1", msip, 1);
        bus(1'b1, 16'h0000, 32'h0, 4'b0000, 1'b0, rd, er);
        check("be0_err", er, 0);
        check("be0_msip", msip, 1);
        wr(16'h0000, 32'h0, 4'b0001);
        check("msip_clr", msip, 0);

        bus(1'b0, 16'h1234, 32'h0, 4'h0, 1'b0, rd, er);
        check("unmapped_err", er, 1);
        check("unmapped_rdata", rd, 0);
        bus(1'b0, 16'h4002, 32'h0, 4'h0, 1'b0, rd, er);
        check("misalign_err", er, 1);
        check("misalign_rdata", rd, 0);
        bus(1'b1, 16'h4002, 32'h0, 4'hF, 1'b0, rd, er);
        check("misalign_wr_err", er, 1);
        bus(1'b0, 16'h4000, 32'h0, 4'h0, 1'b0, rd, er);
        check("misalign_no_change", rd, 32'hFFAB_FFFF);
        bus(1'b1, 16'h0002, 32'h1, 4'hF, 1'b0, rd, er);
        check("msip_misalign_err", er, 1);
        check("msip_misalign_keep", msip, 0);

        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_addr = 16'h4000;
        @(posedge clk);
        #1 req_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("stall_req_ready", req_ready, 0);
            check("stall_resp_valid", resp_valid, 1);
            check("stall_rdata", resp_rdata, 32'hFFAB_FFFF);
        end
        resp_ready = 1'b1;
        @(posedge clk);
        #1 resp_ready = 1'b0;
        @(negedge clk);
        check("retire_valid", resp_valid, 0);
        check("retire_ready", req_ready, 1);

`ifdef CLINT_HI_LATCH_EN
        wr(16'hBFFC, 32'h0, 4'hF);
        wr(16'hBFF8, 32'hFFFF_FFFE, 4'hF);
        bus(1'b0, 16'hBFF8, 32'h0, 4'h0, 1'b0, rd, er);
        check("latch_lo", rd, 32'hFFFF_FFFF);
        bus(1'b0, 16'hBFFC, 32'h0, 4'h0, 1'b0, rd, er);
        check("latch_hi_shadow", rd, 32'h0);
`endif

        sel_dut = 1'b1;
        bus(1'b1, 16'hBFF8, 32'h100, 4'hF, 1'b1, rd, er);
        bus(1'b0, 16'hBFF8, 32'h0, 4'h0, 1'b0, rd, er);
        check("div4_write_wins", rd, 32'h100);
        bus(1'b0, 16'hBFF8, 32'h0, 4'h0, 1'b0, rd, er);
        check("div4_hold", rd, 32'h100);
        bus(1'b0, 16'hBFF8, 32'h0, 4'h0, 1'b0, rd, er);
        check("div4_next_tick", rd, 32'h101);

        sel_dut = 1'b0;
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_addr = 16'h0000;
        @(posedge clk);
        #1 req_valid = 1'b0;
        #2 check("inflight_valid", resp_valid, 1);
        rst_n = 1'b0;
        #1 check("async_rst_valid", resp_valid, 0);
        check("async_rst_ready", req_ready, 1);
        @(negedge clk);
        rst_n = 1'b1;

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
